// File: rtl/n64adv2_dram_arbiter.sv
// -----------------------------------------------------------------------------
// n64adv2_dram_arbiter
//
// Shares the single SDRAM between three clients:
//   * periodic auto-refresh (highest priority),
//   * the HDMI-side output-line reader (read bursts),
//   * the N64-side input-line writer (write bursts).
// Only one command is in flight at a time. The FSM walks IDLE -> ISSUE -> WAIT.
// A command is chosen in IDLE, presented for exactly one cycle in ISSUE, and
// the arbiter then holds NOP in WAIT until the controller reports completion.
//
// Optional feature macro: N64ADV2_DRAM_STARVATION_GUARD_EN
//   When defined, a write that has waited through RD_STREAK_MAX read grants
//   in a row wins over the next read. Refresh still comes first. When the
//   macro is undefined, read always beats write.
//
// Ports
//   DRAM_CLK_i         SDRAM domain clock. All logic uses the rising edge.
//   DRAM_nRST_i        Asynchronous active-low reset.
//   rd_req_i/rd_addr_i Read burst request and address. The request is held
//                      until the grant arrives.
//   rd_gnt_o           One-cycle pulse: the read burst was issued.
//   rd_done_o          One-cycle pulse: the read burst completed.
//   wr_req_i/wr_addr_i Write burst request and address.
//   wr_gnt_o           One-cycle pulse: the write burst was issued.
//   wr_done_o          One-cycle pulse: the write burst completed.
//   ctrl_rdy_i         The controller is idle and initialised.
//   ctrl_cmd_o         Command code: 00 NOP, 01 RD, 10 WR, 11 REFRESH.
//   ctrl_addr_o        Latched burst address that goes with ctrl_cmd_o.
//   ctrl_done_i        One-cycle pulse: the issued command finished.
//   busy_o             High while the FSM is in ISSUE or WAIT.
//   refresh_overrun_o  Sticky flag: the refresh backlog overflowed.
// -----------------------------------------------------------------------------
module n64adv2_dram_arbiter #(
  parameter int ADDR_W         = 22,
  parameter int REFRESH_CYCLES = 780,
  parameter int RD_STREAK_MAX  = 4
) (
  input  logic              DRAM_CLK_i,
  input  logic              DRAM_nRST_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic              rd_done_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  output logic              wr_gnt_o,
  output logic              wr_done_o,
  input  logic              ctrl_rdy_i,
  output logic [1:0]        ctrl_cmd_o,
  output logic [ADDR_W-1:0] ctrl_addr_o,
  input  logic              ctrl_done_i,
  output logic              busy_o,
  output logic              refresh_overrun_o
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] REF_RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_REF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [1:0]        owner_q, owner_d;   // source of the command in flight
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [1:0]        pend_q, pend_d;     // refresh backlog, saturates at 3
  logic              overrun_q, overrun_d;
  logic              expire_s;
  logic              take_ref_s;         // a refresh is selected this cycle
  logic              wr_first_s;         // write beats a competing read

`ifdef N64ADV2_DRAM_STARVATION_GUARD_EN
  localparam int STREAK_W = (RD_STREAK_MAX > 0) ? $clog2(RD_STREAK_MAX + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(RD_STREAK_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Count reads granted past a waiting write. Clear the count once the write wins or goes away.
  always_comb begin
    streak_d = streak_q;
    if (rd_gnt_d && wr_req_i) begin
      if (streak_q == STREAK_LIMIT) begin
        streak_d = streak_q;
      end else begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end else if (wr_gnt_d || !wr_req_i) begin
      streak_d = {STREAK_W{1'b0}};
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge DRAM_CLK_i or negedge DRAM_nRST_i) begin
    if (!DRAM_nRST_i) begin
      streak_q <= {STREAK_W{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

  assign wr_first_s = wr_req_i && (streak_q == STREAK_LIMIT);
`else
  assign wr_first_s = 1'b0;
`endif

  assign expire_s = (ref_cnt_q == {CNT_W{1'b0}});

  // FSM next state and next registered outputs. Every output is registered,
  // so each value computed here becomes visible one cycle later.
  always_comb begin
    state_d    = state_q;
    cmd_d      = CMD_NOP;
    owner_d    = owner_q;
    addr_d     = addr_q;
    rd_gnt_d   = 1'b0;
    wr_gnt_d   = 1'b0;
    rd_done_d  = 1'b0;
    wr_done_d  = 1'b0;
    take_ref_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_rdy_i && ((pend_q != 2'd0) || rd_req_i || wr_req_i)) begin
          state_d = ST_ISSUE;
          if (pend_q != 2'd0) begin
            cmd_d      = CMD_REF;
            owner_d    = CMD_REF;
            take_ref_s = 1'b1;
          end else if (rd_req_i && !wr_first_s) begin
            cmd_d    = CMD_RD;
            owner_d  = CMD_RD;
            addr_d   = rd_addr_i;
            rd_gnt_d = 1'b1;
          end else begin
            // Reached only when a write request is present.
            cmd_d    = CMD_WR;
            owner_d  = CMD_WR;
            addr_d   = wr_addr_i;
            wr_gnt_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctrl_done_i) begin
          state_d   = ST_IDLE;
          rd_done_d = (owner_q == CMD_RD);
          wr_done_d = (owner_q == CMD_WR);
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Refresh interval timer and backlog. When the timer expires in the same
  // cycle that a refresh is taken, the two cancel and the backlog is unchanged.
  always_comb begin
    pend_d    = pend_q;
    overrun_d = overrun_q;
    if (expire_s) begin
      ref_cnt_d = REF_RELOAD;
    end else begin
      ref_cnt_d = ref_cnt_q - CNT_W'(1);
    end
    if (expire_s && !take_ref_s) begin
      if (pend_q == 2'd3) begin
        overrun_d = 1'b1;
      end else begin
        pend_d = pend_q + 2'd1;
      end
    end else if (!expire_s && take_ref_s) begin
      pend_d = pend_q - 2'd1;
    end else begin
      pend_d = pend_q;
    end
  end

  // State, refresh bookkeeping and output registers.
  always_ff @(posedge DRAM_CLK_i or negedge DRAM_nRST_i) begin
    if (!DRAM_nRST_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NOP;
      owner_q   <= CMD_NOP;
      addr_q    <= {ADDR_W{1'b0}};
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
      ref_cnt_q <= REF_RELOAD;
      pend_q    <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      busy_q    <= busy_d;
      ref_cnt_q <= ref_cnt_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign ctrl_cmd_o        = cmd_q;
  assign ctrl_addr_o       = addr_q;
  assign rd_gnt_o          = rd_gnt_q;
  assign wr_gnt_o          = wr_gnt_q;
  assign rd_done_o         = rd_done_q;
  assign wr_done_o         = wr_done_q;
  assign busy_o            = busy_q;
  assign refresh_overrun_o = overrun_q;

endmodule
